// File: rtl/simd_pixel_engine.sv
// In-place SIMD brighten pass over the frame RAM: read, saturating add per 8-bit lane, write back, then signal TX.
// Define SIMD_THRESHOLD_EN to binarise each brightened lane against THRESH.
module simd_pixel_engine #(
  parameter int          RAM_SIZE  = 28,
  parameter int          ADDR_BITS = 5,
  parameter int          DATA_W    = 32,
  parameter logic [7:0]  OFFSET    = 8'd32,
  parameter logic [7:0]  THRESH    = 8'd128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 loadReady,
  input  logic [DATA_W-1:0]    dataOut,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 writeEnable,
  output logic [DATA_W-1:0]    dataIn,
  output logic                 sendStart,
  output logic                 busy
);

  localparam int                   LANES = DATA_W / 8;
  localparam logic [ADDR_BITS-1:0] LAST  = ADDR_BITS'(RAM_SIZE - 1);
`ifdef SIMD_THRESHOLD_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] idx;
  logic                 loadReady_q;
  logic                 trigger;

  function automatic logic [7:0] sat_add(input logic [7:0] p);
    logic [8:0] sum;
    sum = {1'b0, p} + {1'b0, OFFSET};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic [7:0] lane_fn(input logic [7:0] p);
    logic [7:0] s;
    logic [7:0] bin;
    s   = sat_add(p);
    bin = (s >= THRESH) ? 8'hFF : 8'h00;
    return THRESH_EN ? bin : s;
  endfunction

  function automatic logic [DATA_W-1:0] brighten(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] o;
    o = '0;
    for (int l = 0; l < LANES; l++) o[l*8 +: 8] = lane_fn(w[l*8 +: 8]);
    return o;
  endfunction

  // Power-up with the edge register high so a level already present is not a start.
  assign trigger = (state == IDLE) && loadReady && !loadReady_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      loadReady_q <= 1'b1;
      dataIn      <= '0;
    end else begin
      state       <= state_nxt;
      loadReady_q <= loadReady;
      if (state == WAIT) dataIn <= brighten(dataOut);
      if (state == WRITE && idx != LAST) idx <= idx + 1'b1;
      else if (state == DONE) idx <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = READ;
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = WRITE;
      WRITE:   state_nxt = (idx == LAST) ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr        = idx;
    writeEnable = (state == WRITE);
    sendStart   = (state == DONE);
    busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_simd_pixel_engine.sv
// Directed bench for simd_pixel_engine with a behavioural frame RAM and a write scoreboard.
module tb_simd_pixel_engine;

  localparam int N = 28;

  logic        clk = 1'b0;
  logic        reset;
  logic        loadReady;
  logic [31:0] dataOut;
  logic [4:0]  addr;
  logic        writeEnable;
  logic [31:0] dataIn;
  logic        sendStart;
  logic        busy;

  simd_pixel_engine dut (
    .clk(clk), .reset(reset), .loadReady(loadReady), .dataOut(dataOut),
    .addr(addr), .writeEnable(writeEnable), .dataIn(dataIn),
    .sendStart(sendStart), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem  [32];
  logic [31:0] gold [32];

  always @(posedge clk) begin
    if (writeEnable) mem[addr] <= dataIn;
    dataOut <= mem[addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          a;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int ss_cnt = 0;
  int ss_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] w);
    logic [31:0] o;
    logic [8:0]  s;
    logic [7:0]  v;
    o = '0;
    for (int l = 0; l < 4; l++) begin
      s = {1'b0, w[l*8 +: 8]} + 9'd32;
      v = (s > 9'd255) ? 8'hFF : s[7:0];
`ifdef SIMD_THRESHOLD_EN
      v = (v >= 8'd128) ? 8'hFF : 8'h00;
`endif
      o[l*8 +: 8] = v;
    end
    return o;
  endfunction

  // Every write is matched in order against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (writeEnable) begin
      we_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_write_addr", {27'b0, addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("write_addr", {27'b0, addr}, 32'(e.a));
        chk("write_data", dataIn, e.d);
        chk("write_cycle", 32'(cyc), 32'(e.c));
        gold[e.a] = e.d;
      end
    end
    if (sendStart) begin
      ss_cnt++;
      ss_cyc = cyc;
    end
  end

  task automatic wait_until(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic start_pass(output int t);
    t = cyc;
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.a = i;
      e.d = model(gold[i]);
      e.c = t + 3 + 3 * i;
      sb.push_back(e);
    end
    loadReady = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, {27'b0, addr}, 32'd0);
    chk({tag, "_we"}, {31'b0, writeEnable}, 32'd0);
    chk({tag, "_dataIn"}, dataIn, 32'd0);
    chk({tag, "_sendStart"}, {31'b0, sendStart}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int t;
    int w0;
    int s0;
    logic busy_seen;
    logic [31:0] exp0;
    logic [31:0] exp1;

    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h10_80_E0_FF;
    mem[1] = 32'h00_5F_60_C0;
    mem[2] = 32'h00_00_00_00;
    mem[3] = 32'hDF_DF_DF_DF;
    mem[4] = 32'hE0_E0_E0_E0;
    mem[5] = 32'hFF_00_FF_00;
    for (int i = 0; i < 32; i++) gold[i] = mem[i];

    reset = 1'b1;
    loadReady = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Level already high out of reset: no pass.
    reset = 1'b0;
    busy_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy || writeEnable) busy_seen = 1'b1;
    end
    chk("idle_no_pass_activity", {31'b0, busy_seen}, 32'd0);
    chk("idle_no_writes", 32'(we_cnt), 32'd0);

    // Pass 1: plain full pass.
    loadReady = 1'b0;
    repeat (2) @(negedge clk);
    w0 = we_cnt;
    s0 = ss_cnt;
    start_pass(t);
    chk("p1_busy_at_trigger", {31'b0, busy}, 32'd0);
    wait_until(t + 1);
    chk("p1_busy_first_read", {31'b0, busy}, 32'd1);
    chk("p1_we_first_read", {31'b0, writeEnable}, 32'd0);
    wait_until(t + 3);
`ifdef SIMD_THRESHOLD_EN
    exp0 = 32'h00_FF_FF_FF;
    exp1 = 32'h00_00_FF_FF;
`else
    exp0 = 32'h30_A0_FF_FF;
    exp1 = 32'h20_7F_80_E0;
`endif
    chk("p1_word0_we", {31'b0, writeEnable}, 32'd1);
    chk("p1_word0_data", dataIn, exp0);
    wait_until(t + 5);
    chk("p1_dataIn_hold", dataIn, exp0);
    wait_until(t + 85);
    chk("p1_sendStart", {31'b0, sendStart}, 32'd1);
    chk("p1_busy_done", {31'b0, busy}, 32'd1);
    wait_until(t + 86);
    chk("p1_busy_after_done", {31'b0, busy}, 32'd0);
    chk("p1_sendStart_pulse", {31'b0, sendStart}, 32'd0);
    wait_until(t + 120);
    chk("p1_write_count", 32'(we_cnt - w0), 32'd28);
    chk("p1_send_count", 32'(ss_cnt - s0), 32'd1);
    chk("p1_send_cycle", 32'(ss_cyc), 32'(t + 85));
    chk("p1_scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("p1_ram_word1", mem[1], exp1);

    // Pass 2: extra rising edge and a falling level mid-pass are ignored.
    loadReady = 1'b0;
    repeat (2) @(negedge clk);
    w0 = we_cnt;
    s0 = ss_cnt;
    start_pass(t);
    wait_until(t + 38);
    loadReady = 1'b0;
    wait_until(t + 40);
    loadReady = 1'b1;
    wait_until(t + 200);
    chk("p2_write_count", 32'(we_cnt - w0), 32'd28);
    chk("p2_send_count", 32'(ss_cnt - s0), 32'd1);
    chk("p2_send_cycle", 32'(ss_cyc), 32'(t + 85));
    chk("p2_scoreboard_empty", 32'(sb.size()), 32'd0);

    // Pass 3: reset mid-pass aborts without a sendStart.
    loadReady = 1'b0;
    repeat (2) @(negedge clk);
    w0 = we_cnt;
    s0 = ss_cnt;
    start_pass(t);
    wait_until(t + 20);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    chk("abort_writes_before", 32'(we_cnt - w0), 32'd6);
    reset = 1'b0;
    sb.delete();
    w0 = we_cnt;
    repeat (150) @(negedge clk);
    chk("abort_no_send", 32'(ss_cnt - s0), 32'd0);
    chk("abort_no_writes", 32'(we_cnt - w0), 32'd0);

    // Pass 4: engine restarts cleanly on the partly processed RAM.
    loadReady = 1'b0;
    repeat (2) @(negedge clk);
    w0 = we_cnt;
    s0 = ss_cnt;
    start_pass(t);
    wait_until(t + 100);
    chk("p4_write_count", 32'(we_cnt - w0), 32'd28);
    chk("p4_send_cycle", 32'(ss_cyc), 32'(t + 85));
    chk("p4_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
